// File: rtl/bar_pkg.sv
// Shared definitions for the bar-graph column zones: bar indices, the
// column slot table (also used by the raster column-blank decoder) and
// the pointer-encoder FSM states.
package bar_pkg;

  localparam int NUM_BARS = 11;

  localparam logic [3:0] LU4 = 4'd0;
  localparam logic [3:0] LU5 = 4'd1;
  localparam logic [3:0] LU6 = 4'd2;
  localparam logic [3:0] MU1 = 4'd3;
  localparam logic [3:0] MU2 = 4'd4;
  localparam logic [3:0] MU4 = 4'd5;
  localparam logic [3:0] MU5 = 4'd6;
  localparam logic [3:0] MU6 = 4'd7;
  localparam logic [3:0] HU1 = 4'd8;
  localparam logic [3:0] HU2 = 4'd9;
  localparam logic [3:0] HU4 = 4'd10;

  localparam logic [3:0] MISS_INDEX = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } bar_state_e;

  // Column slot occupied by each bar; slots 3, 6, 10, 12 and 14 are gaps.
  function automatic int bar_slot(input logic [3:0] idx);
    case (idx)
      LU4:     bar_slot = 0;
      LU5:     bar_slot = 1;
      LU6:     bar_slot = 2;
      MU1:     bar_slot = 4;
      MU2:     bar_slot = 5;
      MU4:     bar_slot = 7;
      MU5:     bar_slot = 8;
      MU6:     bar_slot = 9;
      HU1:     bar_slot = 11;
      HU2:     bar_slot = 13;
      HU4:     bar_slot = 15;
      default: bar_slot = 0;
    endcase
  endfunction

endpackage

// File: rtl/bar_zone_cmp.sv
// Inclusive range test lo <= x <= lo + PITCH on 13-bit values, so the
// upper bound never wraps for any 12-bit coordinate.
module bar_zone_cmp #(
  parameter int PITCH = 24
) (
  input  logic [12:0] x,
  input  logic [12:0] lo,
  output logic        hit
);

  assign hit = (x >= lo) && (x <= lo + 13'(PITCH));

endmodule

// File: rtl/bar_zone_encoder.sv
// Pointer-to-bar encoder: takes an X coordinate over valid/ready, scans the
// bar zones one per cycle with a single shared comparator, and reports the
// first (lowest-index) zone containing the coordinate, or a miss.
module bar_zone_encoder
  import bar_pkg::*;
#(
  parameter int BLANK_X_OFF = 0,
  parameter int BAR_DETA    = 22
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [11:0]         in_x,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_hit,
  output logic [3:0]          out_index,
  output logic [NUM_BARS-1:0] out_onehot,
  output logic                out_changed
);

  localparam int PITCH = BAR_DETA + 2;
  localparam logic [12:0] LO_INIT = 13'(BLANK_X_OFF + PITCH * bar_slot(LU4));

  // Distance from zone idx's lower bound to zone idx+1's; a constant per
  // index, so the accumulator needs only an adder and a small mux.
  function automatic logic [12:0] lo_step(input logic [3:0] idx);
    lo_step = '0;
    for (int k = 0; k < NUM_BARS - 1; k++) begin
      if (idx == 4'(k))
        lo_step = 13'(PITCH * (bar_slot(4'(k + 1)) - bar_slot(4'(k))));
    end
  endfunction

  bar_state_e  state, state_nxt;
  logic [12:0] x_r;
  logic [12:0] lo_acc;
  logic [3:0]  zone_idx;
  logic [3:0]  last_hit;
  logic        zone_hit;
  logic        accept;
  logic        consume;
  logic        scan_end;

  bar_zone_cmp #(.PITCH(PITCH)) u_cmp (
    .x   (x_r),
    .lo  (lo_acc),
    .hit (zone_hit)
  );

  assign accept   = in_valid & in_ready;
  assign consume  = out_valid & out_ready;
  assign scan_end = (state == ST_SCAN) && (zone_hit || (zone_idx == HU4));

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (scan_end) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Zone counter, registered result and last reported hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zone_idx    <= '0;
      last_hit    <= MISS_INDEX;
      out_hit     <= 1'b0;
      out_index   <= MISS_INDEX;
      out_onehot  <= '0;
      out_changed <= 1'b0;
    end else begin
      if (accept)
        zone_idx <= '0;
      else if ((state == ST_SCAN) && !scan_end)
        zone_idx <= zone_idx + 4'd1;

      if (scan_end) begin
        if (zone_hit) begin
          out_hit     <= 1'b1;
          out_index   <= zone_idx;
          out_onehot  <= NUM_BARS'(1) << zone_idx;
          out_changed <= (zone_idx != last_hit);
        end else begin
          out_hit     <= 1'b0;
          out_index   <= MISS_INDEX;
          out_onehot  <= '0;
          out_changed <= 1'b0;
        end
      end

      if (consume && out_hit) last_hit <= out_index;
    end
  end

  // Latched coordinate and lower-bound accumulator.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_r    <= {1'b0, in_x};
      lo_acc <= LO_INIT;
    end else if (state == ST_SCAN) begin
      lo_acc <= lo_acc + lo_step(zone_idx);
    end
  end

endmodule

// File: doc/bar_zone_encoder.md
# bar_zone_encoder

Pointer-to-bar encoder for the bar-graph display: accepts a horizontal pixel coordinate (touch or mouse X) through a valid/ready handshake. It scans the 11 bar column zones sequentially and returns which bar, if any, the coordinate falls in. The zones are Lu4, Lu5, Lu6, Mu1, Mu2, Mu4, Mu5, Mu6, Hu1, Hu2, Hu4, in that order. It is the inverse of the column-blank decoder: that block turns the raster X counter into per-bar strobes, this block turns an X position back into a bar index. Its output feeds the parameter-select logic of the UI.

## Interface
- BLANK_X_OFF, 0, X of the left edge of zone slot 0.
- BAR_DETA, 22, bar width; slot pitch = BAR_DETA+2.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_x  in  12  pointer X coordinate, sampled on in_valid & in_ready.
- in_valid  in  1  coordinate offered.
- in_ready  out  1  high only in IDLE.
- out_valid  out  1  result held until out_ready.
- out_ready  in  1  result consumed on out_valid & out_ready.
- out_hit  out  1  coordinate lies inside a bar zone.
- out_index  out  4  bar index 0..10 (0=Lu4 … 10=Hu4); 4'hF on miss.
- out_onehot  out  11  bit i set iff out_index==i; all zero on miss.
- out_changed  out  1  hit whose index differs from the last reported hit index.

## Operation
- Zone table, in bar order 0..10: slots 0,1,2,4,5,7,8,9,11,13,15.
- Zone i covers lo = BLANK_X_OFF + pitch*slot(i) to hi = lo + pitch, with both ends inclusive.
- Adjacent zones share a boundary pixel. On an overlap, the lowest bar index wins.
- Bounds are computed in 13 bits, so there is no wrap-around. An X beyond every zone is a miss.
- FSM states:
  - IDLE: in_ready=1. On accept, latch in_x, set zone counter to 0, and go to SCAN.
  - SCAN: evaluate one zone per cycle. The lower bound is kept in an accumulator advanced by pitch×(slot step); no multiplier.
    - On the first hit, or after zone 10 misses, register the result and go to DONE.
  - DONE: out_valid=1 and outputs stable. On out_ready, go to IDLE.
- last_hit index register:
  - reset value 4'hF;
  - updated on every consumed hit;
  - a miss does not change it;
  - out_changed = out_hit & (out_index != last_hit).
- Reset values: state IDLE, out_valid=0, out_hit=0, out_index=4'hF, out_onehot=0, out_changed=0, in_ready=1 (after reset release), last_hit=4'hF.

## Timing
- Accept at cycle T.
- Zone i is compared in cycle T+1+i.
- Hit in zone i: out_valid rises at T+2+i.
- Miss: out_valid rises at T+12.
- Back-to-back: after consume at cycle C, IDLE in C+1. Next accept at the earliest C+1.
- in_valid while busy is ignored (in_ready=0). The source must hold it.
- Outputs change only on entry to DONE or on reset.
- Asynchronous reset mid-SCAN or mid-DONE:
  - immediate return to IDLE with reset values;
  - the pending result is discarded;
  - last_hit is cleared.

## Structure
- Shared package bar_pkg holds:
  - NUM_BARS=11;
  - the slot table (0,1,2,4,5,7,8,9,11,13,15);
  - bar index localparams (LU4…HU4);
  - MISS_INDEX=4'hF;
  - the FSM state enum.
- The raster decoder reuses the same slot table.
- Sub-module bar_zone_cmp: combinational test of lo <= x <= lo+pitch, 13-bit. One instance is time-shared by the scan.

## Test plan
- Defaults, x=0 → out_hit=1, out_index=0, onehot=11'h001, out_changed=1, out_valid at T+2.
- x=24 (Lu4/Lu5 shared pixel) → index 0. Then x=25 → index 1, out_changed=1, valid at T+3.
- x=80 (gap slot 3) → out_hit=0, index 4'hF, onehot 0, valid at T+12, last_hit unchanged.
- x=360 → index 10 (Hu4), valid at T+12.
  - x=385 → miss.
  - x=350 (gap slot 14) → miss.
- Repeat x=100 twice → index 3 both times, out_changed 1 then 0.
- Backpressure and reset:
  - hold out_ready low 5 cycles → outputs stable, in_ready=0;
  - assert reset at T+4 of a scan of x=300 → outputs return to reset values at once, in_ready=1 after release.
